// File: rtl/prog_loader_if.sv
// Host serial link and program-RAM write port of the SAP-1 program loader.
// The host or bench side takes master; the loader takes slave.
interface prog_loader_if;
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned DATA_W = 8;

  logic              sclk;
  logic              sdi;
  logic              cs_n;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic              cpu_rst;
  logic              done;
  logic              error;

  modport master (
    output sclk, sdi, cs_n,
    input  mem_we, mem_addr, mem_data, cpu_rst, done, error
  );

  modport slave (
    input  sclk, sdi, cs_n,
    output mem_we, mem_addr, mem_data, cpu_rst, done, error
  );
endinterface

// File: rtl/prog_loader.sv
// Serial program loader: receives a count byte followed by N data bytes over a
// host-clocked serial link and writes them into the 16x8 program RAM.
module prog_loader (
  input  logic          clk,
  input  logic          rst,
  prog_loader_if.slave  bus
);
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned CNT_W  = 5;
  localparam int unsigned BIT_W  = 3;
  localparam int unsigned MAX_N  = 16;

  typedef enum logic [2:0] {IDLE, HEADER, DATA, DONE, ERR} state_t;

  state_t              r_state;
  state_t              w_next;
  logic [1:0]          r_sclk_s;
  logic [1:0]          r_sdi_s;
  logic [1:0]          r_cs_s;
  logic                r_sclk_prev;
  logic                r_cs_prev;
  logic [BYTE_W-1:0]   r_shift;
  logic [BIT_W-1:0]    r_bitcnt;
  logic [CNT_W-1:0]    r_n;
  logic [CNT_W-1:0]    r_wr_cnt;
  logic                r_mem_we;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [BYTE_W-1:0]   r_mem_data;
  logic                r_cpu_rst;
  logic                r_done;
  logic                r_error;

  logic                w_sclk_rise;
  logic                w_cs_fall;
  logic                w_cs_rise;
  logic                w_byte_done;
  logic [BYTE_W-1:0]   w_byte;
  logic                w_hdr_ok;
  logic                w_wr_go;

  // Two-flop synchronizers plus previous-value taps for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sclk_s    <= '0;
      r_sdi_s     <= '0;
      r_cs_s      <= '0;
      r_sclk_prev <= 1'b0;
      r_cs_prev   <= 1'b0;
    end else begin
      r_sclk_s    <= {r_sclk_s[0], bus.sclk};
      r_sdi_s     <= {r_sdi_s[0], bus.sdi};
      r_cs_s      <= {r_cs_s[0], bus.cs_n};
      r_sclk_prev <= r_sclk_s[1];
      r_cs_prev   <= r_cs_s[1];
    end
  end

  assign w_sclk_rise = r_sclk_s[1] & ~r_sclk_prev;
  assign w_cs_fall   = ~r_cs_s[1] & r_cs_prev;
  assign w_cs_rise   = r_cs_s[1] & ~r_cs_prev;
  assign w_byte_done = w_sclk_rise & ~r_cs_s[1] & (r_bitcnt == BIT_W'(7));
  assign w_byte      = {r_shift[BYTE_W-2:0], r_sdi_s[1]};
  assign w_hdr_ok    = (w_byte != '0) && (w_byte <= BYTE_W'(MAX_N));
  assign w_wr_go     = (r_state == DATA) && w_byte_done && (r_wr_cnt < r_n);

  // Deserializer, held clear while the host deselects
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shift  <= '0;
      r_bitcnt <= '0;
    end else if (r_cs_s[1]) begin
      r_shift  <= '0;
      r_bitcnt <= '0;
    end else if (w_sclk_rise) begin
      r_shift  <= w_byte;
      r_bitcnt <= r_bitcnt + BIT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE, DONE, ERR: if (w_cs_fall) w_next = HEADER;
      HEADER: begin
        if (w_cs_rise)        w_next = ERR;
        else if (w_byte_done) w_next = w_hdr_ok ? DATA : ERR;
      end
      DATA: begin
        // The final strobe is issued while still in DATA; DONE follows it
        if (r_mem_we && (r_wr_cnt == r_n)) w_next = DONE;
        else if (w_cs_rise)                w_next = ERR;
      end
      default: w_next = IDLE;
    endcase
  end

  // Registered write port and status outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_n        <= '0;
      r_wr_cnt   <= '0;
      r_mem_we   <= 1'b0;
      r_mem_addr <= '0;
      r_mem_data <= '0;
      r_cpu_rst  <= 1'b1;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
    end else begin
      r_mem_we  <= w_wr_go;
      r_cpu_rst <= (w_next != DONE);
      r_done    <= (w_next == DONE);
      r_error   <= (w_next == ERR);
      if ((r_state == HEADER) && w_byte_done && w_hdr_ok) begin
        r_n      <= CNT_W'(w_byte);
        r_wr_cnt <= '0;
      end
      if (w_wr_go) begin
        r_mem_addr <= r_wr_cnt[ADDR_W-1:0];
        r_mem_data <= w_byte;
        r_wr_cnt   <= r_wr_cnt + CNT_W'(1);
      end
    end
  end

  assign bus.mem_we   = r_mem_we;
  assign bus.mem_addr = r_mem_addr;
  assign bus.mem_data = r_mem_data;
  assign bus.cpu_rst  = r_cpu_rst;
  assign bus.done     = r_done;
  assign bus.error    = r_error;
endmodule
